// File: rtl/lfsr_pkg.sv
// lfsr_pkg
//   Shared constants, FSM state type and the LFSR step function for the
//   shared pseudo-random byte generator. There are no ports; the package is
//   imported by lfsr_step_core and lfsr_rng_arbiter.
package lfsr_pkg;

   localparam int          LFSR_W     = 8;
   localparam logic [7:0]  LFSR_TAPS  = 8'h1D;   // bits 4, 3, 2, 0
   localparam logic [7:0]  LFSR_RESET = 8'h01;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ADVANCE = 2'd1,
      GRANT   = 2'd2
   } state_t;

   // One Fibonacci shift: feedback is the parity of the tapped bits and
   // enters at the MSB. An all-zero state would lock up, so it restarts at 1.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      if (s == '0) begin
         return LFSR_RESET;
      end
      return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
   endfunction

endpackage

// File: rtl/lfsr_step_core.sv
// lfsr_step_core
//   8-bit Fibonacci LFSR register with load and step enables.
//   Ports:
//     clk    in   clock
//     reset  in   asynchronous active-low reset (state -> 0x01)
//     en     in   advance the LFSR by one step
//     load   in   load seed (takes priority over en); 0x00 becomes 0x01
//     seed   in   [7:0] value to load
//     state  out  [7:0] current LFSR state
module lfsr_step_core
   import lfsr_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   output logic [LFSR_W-1:0] state
);

   logic [LFSR_W-1:0] state_q;
   logic [LFSR_W-1:0] state_d;

   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = (seed == '0) ? LFSR_RESET : seed;
      end else if (en) begin
         state_d = lfsr_next(state_q);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= LFSR_RESET;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/lfsr_rng_arbiter.sv
// lfsr_rng_arbiter
//   Shares one LFSR among N_REQ requesters. A round-robin arbiter picks a
//   pending requester, the LFSR is advanced STEPS times, then the byte is
//   delivered with a one-cycle one-hot grant.
//   Ports:
//     clk        in   clock
//     reset      in   asynchronous active-low reset
//     req        in   [N_REQ-1:0] requests, held until granted
//     seed_load  in   pulse: load seed into the LFSR
//     seed       in   [7:0] new LFSR state (0x00 loads 0x01)
//     gnt        out  [N_REQ-1:0] one-hot grant pulse
//     rnd_valid  out  high while gnt is non-zero
//     rnd_data   out  [7:0] current LFSR state (the random byte during gnt)
//     busy       out  high in ADVANCE and GRANT
module lfsr_rng_arbiter
   import lfsr_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int STEPS = 8
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic [N_REQ-1:0]  req,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed,
   output logic [N_REQ-1:0]  gnt,
   output logic              rnd_valid,
   output logic [LFSR_W-1:0] rnd_data,
   output logic              busy
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = 8;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   winner_q, winner_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               lfsr_en;
   logic [LFSR_W-1:0]  lfsr_state;

   logic [PTR_W-1:0]   next_ptr;
   logic [PTR_W-1:0]   arb_base;
   int                 arb_span;
   logic               arb_found;
   logic [PTR_W-1:0]   arb_idx;

   lfsr_step_core u_core (
      .clk   (clk),
      .reset (reset),
      .en    (lfsr_en),
      .load  (seed_load),
      .seed  (seed),
      .state (lfsr_state)
   );

   // Pointer value after the current winner is served.
   assign next_ptr = (winner_q == PTR_W'(N_REQ-1)) ? '0 : winner_q + 1'b1;

   // In GRANT the search starts just past the winner and covers only the
   // other N_REQ-1 requesters, so the winner cannot be picked twice in a row.
   assign arb_base = (state_q == GRANT) ? next_ptr : ptr_q;
   assign arb_span = (state_q == GRANT) ? N_REQ - 1 : N_REQ;

   always_comb begin
      int idx;
      idx       = 0;
      arb_found = 1'b0;
      arb_idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(arb_base) + k;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         if (!arb_found && (k < arb_span) && req[idx]) begin
            arb_found = 1'b1;
            arb_idx   = PTR_W'(idx);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      winner_d = winner_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      lfsr_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (arb_found) begin
               winner_d = arb_idx;
               cnt_d    = '0;
               state_d  = ADVANCE;
            end
         end
         ADVANCE: begin
            if (seed_load) begin
               // Restart the count so a full STEPS shifts follow the new seed.
               cnt_d = '0;
            end else begin
               lfsr_en = 1'b1;
               if (cnt_q == CNT_W'(STEPS-1)) begin
                  state_d = GRANT;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         GRANT: begin
            ptr_d = next_ptr;
            if (arb_found) begin
               winner_d = arb_idx;
               cnt_d    = '0;
               state_d  = ADVANCE;
            end else begin
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         winner_q <= '0;
         ptr_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         winner_q <= winner_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // All outputs decode registered state only.
   always_comb begin
      gnt = '0;
      if (state_q == GRANT) begin
         gnt[winner_q] = 1'b1;
      end
   end

   assign rnd_valid = (state_q == GRANT);
   assign rnd_data  = lfsr_state;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// tb_lfsr_rng_arbiter
//   Self-checking bench: directed scenarios plus randomized traffic, checked
//   every cycle against a behavioural model, with literal expectations at the
//   key points of the directed scenarios.
module tb_lfsr_rng_arbiter;

   localparam int N     = 4;
   localparam int STEPS = 8;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic [N-1:0]   req = '0;
   logic           seed_load = 1'b0;
   logic [7:0]     seed = 8'h00;
   logic [N-1:0]   gnt;
   logic           rnd_valid;
   logic [7:0]     rnd_data;
   logic           busy;

   lfsr_rng_arbiter #(.N_REQ(N), .STEPS(STEPS)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .seed_load (seed_load),
      .seed      (seed),
      .gnt       (gnt),
      .rnd_valid (rnd_valid),
      .rnd_data  (rnd_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // ---------------- behavioural model ----------------
   logic [7:0] m_lfsr;
   int         m_left;     // shifts still owed before the grant (0 = none)
   bit         m_gr;       // grant being presented this cycle
   int         m_win;
   int         m_ptr;

   function automatic logic [7:0] step8(input logic [7:0] s);
      int v, fb;
      v = int'(s);
      if (v == 0) return 8'h01;
      fb = ((v >> 4) ^ (v >> 3) ^ (v >> 2) ^ v) & 1;
      return 8'((fb << 7) | (v >> 1));
   endfunction

   function automatic int pick(input int from, input int span, input logic [N-1:0] r);
      for (int k = 0; k < span; k++) begin
         int j;
         j = (from + k) % N;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_lfsr = 8'h01; m_left = 0; m_gr = 0; m_win = 0; m_ptr = 0;
   endtask

   task automatic model_clock();
      logic [7:0] ld;
      int w;
      ld = (seed == 8'h00) ? 8'h01 : seed;
      if (!reset) begin
         model_reset();
      end else if (m_gr) begin
         m_ptr = (m_win + 1) % N;
         if (seed_load) m_lfsr = ld;
         m_gr = 0;
         w = pick(m_ptr, N - 1, req);
         if (w >= 0) begin m_win = w; m_left = STEPS; end
      end else if (m_left > 0) begin
         if (seed_load) begin
            m_lfsr = ld; m_left = STEPS;
         end else begin
            m_lfsr = step8(m_lfsr);
            m_left--;
            if (m_left == 0) m_gr = 1;
         end
      end else begin
         if (seed_load) m_lfsr = ld;
         w = pick(m_ptr, N, req);
         if (w >= 0) begin m_win = w; m_left = STEPS; end
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic check_model();
      logic [N-1:0] eg;
      eg = m_gr ? N'(1 << m_win) : '0;
      chk("gnt",       32'(gnt),       32'(eg));
      chk("rnd_valid", 32'(rnd_valid), 32'(m_gr));
      chk("rnd_data",  32'(rnd_data),  32'(m_lfsr));
      chk("busy",      32'(busy),      32'(m_gr || (m_left > 0)));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_clock();
      @(negedge clk);
      cyc++;
      check_model();
      if (gnt != '0)
         $display("grant cycle=%0d gnt=%b data=%02h", cyc, gnt, rnd_data);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      #1;
      chk("rst_gnt",   32'(gnt),       32'h0);
      chk("rst_valid", 32'(rnd_valid), 32'h0);
      chk("rst_busy",  32'(busy),      32'h0);
      chk("rst_data",  32'(rnd_data),  32'h01);
      @(negedge clk);
      reset = 1'b1;
      cyc = 0;
   endtask

   // Waits (bounded) for a grant; n is the number of cycles taken.
   task automatic wait_grant(input int max, output int n, output logic [N-1:0] g,
                             output logic [7:0] d);
      n = 0; g = '0; d = '0;
      while (n < max) begin
         cycle();
         n++;
         if (gnt != '0) begin g = gnt; d = rnd_data; return; end
      end
      n_cmp++; n_bad++;
      $display("FAIL grant_timeout: no gnt within %0d cycles, expected one", max);
   endtask

   task automatic settle();
      req = '0; seed_load = 1'b0;
      repeat (3) cycle();
   endtask

   int          n;
   logic [N-1:0] g;
   logic [7:0]  d, prev_d;
   logic [N-1:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   int          grants_seen;

   initial begin
      model_reset();
      #1;
      do_reset();

      // Single request after reset
      req = 4'b0001;
      wait_grant(30, n, g, d);
      chk("single_latency", 32'(n), 32'd9);
      chk("single_gnt",     32'(g), 32'b0001);
      chk("single_data",    32'(d), 32'h71);
      settle();

      // Round robin with continuous demand
      do_reset();
      req = 4'b1111;
      prev_d = 8'h00;
      for (int i = 0; i < 5; i++) begin
         wait_grant(30, n, g, d);
         chk("rr_spacing", 32'(n), 32'd9);
         chk("rr_gnt",     32'(g), 32'(rr_exp[i]));
         if (i > 0) begin
            n_cmp++;
            if (d == prev_d) begin
               n_bad++;
               $display("FAIL rr_data_differ: got %02h, expected != %02h", d, prev_d);
            end
         end
         prev_d = d;
      end
      settle();

      // Zero seed in IDLE restarts the post-reset sequence
      seed = 8'h00; seed_load = 1'b1;
      cycle();
      seed_load = 1'b0;
      req = 4'b0100;
      wait_grant(30, n, g, d);
      chk("zseed_gnt",  32'(g), 32'b0100);
      chk("zseed_data", 32'(d), 32'h71);
      settle();

      // Seed load in the 4th ADVANCE cycle
      req = 4'b0001;
      repeat (4) cycle();
      seed = 8'h01; seed_load = 1'b1;
      cycle();
      seed_load = 1'b0;
      wait_grant(30, n, g, d);
      chk("midseed_latency", 32'(n + 5), 32'd13);
      chk("midseed_data",    32'(d),     32'h71);
      settle();

      // Withdrawal after the winner is latched
      req = 4'b0010;
      cycle();
      req = 4'b0000;
      wait_grant(30, n, g, d);
      chk("withdraw_gnt",     32'(g),     32'b0010);
      chk("withdraw_latency", 32'(n + 1), 32'd9);
      settle();

      // Reset during ADVANCE drops the pending grant
      req = 4'b0001;
      repeat (4) cycle();
      req = '0;
      do_reset();
      grants_seen = 0;
      repeat (15) begin
         cycle();
         if (gnt != '0) grants_seen++;
      end
      chk("abort_no_grant", 32'(grants_seen), 32'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         req       = N'($urandom);
         seed_load = ($urandom_range(0, 15) == 0);
         seed      = 8'($urandom);
         if ($urandom_range(0, 3) == 0) seed = 8'h00;
         cycle();
      end
      settle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lfsr_rng_arbiter.md
# lfsr_rng_arbiter

Shares one 8-bit Fibonacci LFSR among `N_REQ` requesters, each of which needs a fresh pseudo-random byte. A round-robin arbiter picks one pending requester. The LFSR is advanced `STEPS` times so no two grants see correlated bits. The byte is then delivered with a one-cycle grant pulse. The block also lets software reseed the generator at any time.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `STEPS`, default 8: LFSR shifts between deliveries, 1..255.
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, asynchronous, active-low. Clock is `clk`.
- `req`, in, `N_REQ`: per-requester request. Held high until the matching `gnt` bit pulses.
- `seed_load`, in, 1: single-cycle pulse that loads `seed` into the LFSR.
- `seed`, in, 8: new LFSR state. `0x00` is replaced by `0x01`.
- `gnt`, out, `N_REQ`: one-hot grant pulse, one cycle.
- `rnd_valid`, out, 1: high exactly when `gnt` is non-zero.
- `rnd_data`, out, 8: random byte. Valid while `rnd_valid` is high and holds the current LFSR state otherwise.
- `busy`, out, 1: high in the ADVANCE and GRANT states.

## Operation
- **LFSR step:** `fb = s[4]^s[3]^s[2]^s[0]`; next `s = {fb, s[7:1]}`.
- **Zero guard:** a step taken from `s == 0x00` yields `0x01`.
- **Reset values:** LFSR state `0x01`, FSM IDLE, round-robin pointer 0, step counter 0, `gnt` = 0, `rnd_valid` = 0, `busy` = 0, `rnd_data` = `0x01`.
- **IDLE state:** if any `req` bit is high, the arbiter latches the winner, clears the counter and moves to ADVANCE. The LFSR does not step in IDLE.
- **ADVANCE state:** the LFSR steps once per cycle and the counter increments. When the counter reaches `STEPS-1` on a stepping cycle, the FSM moves to GRANT.
- **GRANT state:**
  - `gnt[winner]` = 1, `rnd_valid` = 1, `rnd_data` = LFSR state; the LFSR does not step.
  - The pointer is set to `winner+1`, wrapping at `N_REQ`.
  - Rearbitration excludes `winner`. If another request is pending, the new winner is latched and the FSM goes to ADVANCE with the counter cleared; otherwise it goes to IDLE.
- **Arbitration rule:** the lowest index at or above the pointer wins, with wrap-around.
- **Request withdrawal:** if the latched winner drops `req` before its grant, the grant is still issued. No retraction.
- **Seed load:**
  - `seed_load` wins over stepping in every state: the LFSR takes `seed`, or `0x01` if `seed` is zero.
  - In ADVANCE, the counter also clears, so a full `STEPS` shifts follow the new seed.
  - In GRANT, `rnd_data` shows the pre-load state and the load takes effect at the clock edge.
- **Reset mid-operation:** all state returns to reset values immediately. Any pending grant is dropped.

## Timing
- Request high in IDLE at cycle 0 → ADVANCE in cycles 1..`STEPS` → `gnt`/`rnd_valid` in cycle `STEPS+1`.
- With continuous demand, there is one grant every `STEPS+1` cycles.
- Outputs are registered or decoded from registered state only. There is no combinational path from `req` or `seed` to any output.

## Structure
- **Package `lfsr_pkg`:**
  - `LFSR_W = 8`.
  - `LFSR_TAPS = 8'h1D` (bits 4, 3, 2, 0).
  - `LFSR_RESET = 8'h01`.
  - State enum {IDLE, ADVANCE, GRANT}.
- **Sub-module `lfsr_step_core`:**
  - Ports: `clk`, `reset`, `en`, `load`, `seed[7:0]`, `state[7:0]`.
  - Priority is `load` > `en`, and it includes the zero guard.
- **Top level:** holds the FSM, the step counter and the round-robin pointer/priority encoder.

## Test plan
- **Reset, single request:** after reset, pulse `req` = `0001` and hold it. Then `gnt` = `0001` in cycle 9 with `rnd_data` = `0x71`. The LFSR path is `0x80, 0x40, 0x20, 0x10, 0x88, 0xC4, 0xE2, 0x71`.
- **Round robin:** hold `req` = `1111` continuously. Grants go `0001, 0010, 0100, 1000, 0001`, spaced 9 cycles apart, and successive data differ.
- **Zero seed:** `seed_load` with `seed = 0x00` in IDLE, then `req[2]`. The grant shows `0x71`, i.e. identical to the post-reset sequence.
- **Seed mid-ADVANCE:** `seed_load` with `seed = 0x01` in the 4th ADVANCE cycle. The grant is delayed until 8 steps after the load, and `rnd_data = 0x71`.
- **Withdrawal and reset abort:**
  - Drop `req[1]` after the winner is latched; `gnt[1]` still pulses.
  - Separately, assert `reset` during ADVANCE: no grant is issued, and outputs read `0` / `0x01` immediately.
